// File: rtl/jk_excite_pkg.sv
// Shared types and defaults for the JK flop-bank excitation controller.
package jk_excite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic MODE_HOLD   = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    localparam int DEFAULT_W         = 4;
    localparam int DEFAULT_MAX_RETRY = 3;

    // Counter must hold 0..max_retry; never collapse to a zero-width vector.
    function automatic int retry_width(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation decode: present state and wanted state to J/K,
// with the don't-care input resolved by mode.
module jk_excite_bit (
    input  logic q,
    input  logic q_next,
    input  logic mode,
    output logic j,
    output logic k
);

    // Excitation table with the free input taken from mode
    always_comb begin
        if (q == 1'b0) begin
            j = q_next;
            k = mode;
        end else begin
            j = mode;
            k = ~q_next;
        end
    end

endmodule

// File: rtl/jk_excite.sv
// Drives a JK flop bank toward a requested target, verifies it through Q
// feedback and re-drives a bounded number of times before flagging an error.
module jk_excite
    import jk_excite_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [W-1:0] tgt,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic         mode,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         done,
    output logic         err
);

    localparam int RW = retry_width(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t          state_r;
    state_t          state_next_s;
    logic [W-1:0]    tgt_r;
    logic            mode_r;
    logic [RW-1:0]   retry_r;
    logic [W-1:0]    dec_j_s;
    logic [W-1:0]    dec_k_s;
    logic            match_s;
    logic            retry_left_s;

    assign match_s      = (q_fb == tgt_r);
    assign retry_left_s = (retry_r < RETRY_MAX);

    for (genvar i = 0; i < W; i++) begin : gen_bit
        jk_excite_bit u_bit (
            .q      (q_fb[i]),
            .q_next (tgt_r[i]),
            .mode   (mode_r),
            .j      (dec_j_s[i]),
            .k      (dec_k_s[i])
        );
    end

    // FSM state register
    always_ff @(posedge ck) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (tgt_valid) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: state_next_s = CHECK;
            CHECK: begin
                if (match_s) begin
                    state_next_s = IDLE;
                end else if (retry_left_s) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Target/mode capture and saturating retry count
    always_ff @(posedge ck) begin
        if (rst) begin
            tgt_r   <= {W{1'b0}};
            mode_r  <= MODE_HOLD;
            retry_r <= {RW{1'b0}};
        end else if ((state_r == IDLE) && tgt_valid) begin
            tgt_r   <= tgt;
            mode_r  <= mode;
            retry_r <= {RW{1'b0}};
        end else if ((state_r == CHECK) && !match_s && retry_left_s) begin
            retry_r <= retry_r + RW'(1'b1);
        end else begin
            retry_r <= retry_r;
        end
    end

    // FSM outputs; reset forces the bank to hold and suppresses pulses
    always_comb begin
        tgt_ready = (state_r == IDLE);
        j         = {W{1'b0}};
        k         = {W{1'b0}};
        done      = 1'b0;
        err       = 1'b0;
        if (rst) begin
            j    = {W{1'b0}};
            k    = {W{1'b0}};
            done = 1'b0;
            err  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done = 1'b0;
                end
                DRIVE: begin
                    j = dec_j_s;
                    k = dec_k_s;
                end
                CHECK: begin
                    done = match_s;
                    err  = !match_s && !retry_left_s;
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite.sv
// Bench for jk_excite: JK flop-bank model on the outputs, directed vector
// table, hand-written corner sequences and randomized model-checked traffic.
module tb_jk_excite;

    localparam int W  = 4;
    localparam int MR = 3;

    logic         ck;
    logic         rst;
    logic [W-1:0] tgt;
    logic         tgt_valid;
    logic         tgt_ready;
    logic         mode;
    logic [W-1:0] q_fb;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         done;
    logic         err;

    jk_excite #(.W(W), .MAX_RETRY(MR)) dut (
        .ck        (ck),
        .rst       (rst),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .mode      (mode),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .done      (done),
        .err       (err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Flop bank model with optional stuck-at-0 bits and a direct load port
    logic [W-1:0] bank_q;
    logic [W-1:0] stuck;
    logic         bank_load;
    logic [W-1:0] bank_load_val;
    always_ff @(posedge ck) begin
        if (bank_load) bank_q <= bank_load_val;
        else           bank_q <= ((j & ~bank_q) | (~k & bank_q)) & ~stuck;
    end
    assign q_fb = bank_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: op in progress and cycle index within it
    logic         m_busy = 1'b0;
    int           m_n    = 0;
    logic [W-1:0] m_tgt;
    logic         m_mode;

    logic [W-1:0] obs_j, obs_k;
    logic         obs_done, obs_err, obs_ready;

    task automatic cycle(input logic r, input logic v, input logic [W-1:0] t, input logic m);
        logic [W-1:0] mm, ej, ek;
        logic e_done, e_err;
        rst = r; tgt_valid = v; tgt = t; mode = m;
        #1;
        obs_j = j; obs_k = k; obs_done = done; obs_err = err; obs_ready = tgt_ready;
        ej = '0; ek = '0; e_done = 1'b0; e_err = 1'b0;
        mm = {W{m_mode}};
        if (m_busy && !r && (m_n % 2 == 1)) begin
            ej = (~q_fb & m_tgt) | (q_fb & mm);
            ek = (~q_fb & mm) | (q_fb & ~m_tgt);
        end
        if (m_busy && !r && (m_n % 2 == 0)) begin
            e_done = (q_fb == m_tgt);
            e_err  = !e_done && (m_n == 2 * (MR + 1));
        end
        chk("m_ready", obs_ready, !m_busy);
        chk("m_j", obs_j, ej);
        chk("m_k", obs_k, ek);
        chk("m_done", obs_done, e_done);
        chk("m_err", obs_err, e_err);
        if (r) m_busy = 1'b0;
        else if (!m_busy) begin
            if (v) begin m_busy = 1'b1; m_n = 1; m_tgt = t; m_mode = m; end
        end else if (e_done || e_err) m_busy = 1'b0;
        else m_n++;
        @(posedge ck);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] start;
        logic [W-1:0] tgt;
        logic         mode;
        logic [W-1:0] stuck;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic         exp_done;
        int           cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic load_bank(input logic [W-1:0] val);
        bank_load = 1'b1; bank_load_val = val;
        cycle(1'b0, 1'b0, '0, 1'b0);
        bank_load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0000, 4'b1010, 1'b0, 4'b0000, 4'b1010, 4'b0000, 1'b1, 2};
        vecs[1] = '{4'b1111, 4'b0101, 1'b1, 4'b0000, 4'b1111, 4'b1010, 1'b1, 2};
        vecs[2] = '{4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 8};
        vecs[3] = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2};
        vecs[4] = '{4'b0110, 4'b0110, 1'b1, 4'b0000, 4'b0110, 4'b1001, 1'b1, 2};
        vecs[5] = '{4'b1010, 4'b0101, 1'b0, 4'b0000, 4'b0101, 4'b1010, 1'b1, 2};
        vecs[6] = '{4'b0011, 4'b1100, 1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1, 2};

        rst = 1'b1; tgt_valid = 1'b0; tgt = '0; mode = 1'b0;
        stuck = '0; bank_load = 1'b1; bank_load_val = '0;
        @(posedge ck);
        #1;
        // Reset state, with a target offered during reset that must be dropped
        cycle(1'b1, 1'b1, 4'b1111, 1'b1);
        chk("rst_j", obs_j, 4'b0000);
        chk("rst_k", obs_k, 4'b0000);
        chk("rst_done", obs_done, 1'b0);
        chk("rst_err", obs_err, 1'b0);
        bank_load = 1'b0;
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("rst_ready", obs_ready, 1'b1);
        chk("rst_drop_j", obs_j, 4'b0000);

        // Directed vector table
        foreach (vecs[vi]) begin
            stuck = vecs[vi].stuck;
            load_bank(vecs[vi].start);
            cycle(1'b0, 1'b1, vecs[vi].tgt, vecs[vi].mode);
            chk("vec_accept_ready", obs_ready, 1'b1);
            for (int n = 1; n <= vecs[vi].cycles; n++) begin
                cycle(1'b0, 1'b0, '0, 1'b0);
                if (n == 1) begin
                    chk("vec_j", obs_j, vecs[vi].ej);
                    chk("vec_k", obs_k, vecs[vi].ek);
                end
                chk("vec_busy_ready", obs_ready, 1'b0);
                chk("vec_done", obs_done, (n == vecs[vi].cycles) && vecs[vi].exp_done);
                chk("vec_err", obs_err, (n == vecs[vi].cycles) && !vecs[vi].exp_done);
            end
            cycle(1'b0, 1'b0, '0, 1'b0);
            chk("vec_idle_ready", obs_ready, 1'b1);
            if (vecs[vi].exp_done) chk("vec_final_q", bank_q, vecs[vi].tgt);
            stuck = '0;
        end

        // TGT_VALID held high with a different target while busy
        load_bank(4'b0000);
        cycle(1'b0, 1'b1, 4'b1100, 1'b0);
        cycle(1'b0, 1'b1, 4'b0011, 1'b0);
        chk("hold_j", obs_j, 4'b1100);
        chk("hold_ready_drive", obs_ready, 1'b0);
        cycle(1'b0, 1'b1, 4'b0011, 1'b0);
        chk("hold_done", obs_done, 1'b1);
        chk("hold_ready_check", obs_ready, 1'b0);
        chk("hold_q", bank_q, 4'b1100);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("hold_idle_ready", obs_ready, 1'b1);

        // Reset during DRIVE aborts silently
        load_bank(4'b0000);
        cycle(1'b0, 1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("abort_j", obs_j, 4'b0000);
        chk("abort_k", obs_k, 4'b0000);
        chk("abort_ready", obs_ready, 1'b1);
        chk("abort_done", obs_done, 1'b0);
        chk("abort_err", obs_err, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("abort_done2", obs_done, 1'b0);
        chk("abort_q", bank_q, 4'b0000);

        // Randomized traffic against the reference model
        for (int it = 0; it < 600; it++) begin
            logic r, v, m;
            logic [W-1:0] t;
            r = ($urandom_range(0, 39) == 0);
            v = $urandom_range(0, 1);
            t = W'($urandom_range(0, 15));
            m = $urandom_range(0, 1);
            if ($urandom_range(0, 24) == 0)
                stuck = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : '0;
            bank_load = ($urandom_range(0, 19) == 0);
            bank_load_val = W'($urandom_range(0, 15));
            cycle(r, v, t, m);
            bank_load = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
